// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_seq_ctrl (with add32 adder wrapper)
// Brief    : Multi-cycle MULT/MULTU sequencer producing HI/LO via one adder.
// Revision : 1.0
// ============================================================================

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b};
  assign overflow    = (a[31] == b[31]) && (sum[31] != a[31]);
endmodule

module mult_seq_ctrl #(
  parameter int WIDTH = 32  // must stay 32 to match add32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PREP_A = 3'd1;
  localparam logic [2:0] S_PREP_B = 3'd2;
  localparam logic [2:0] S_MUL    = 3'd3;
  localparam logic [2:0] S_FIX_LO = 3'd4;
  localparam logic [2:0] S_FIX_HI = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [4:0]       count;
  logic             sgn;
  logic             neg;
  logic             carry_r;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             add_ovf_unused;

  // Single shared adder: operands steered by state so every step reuses it.
  always_comb begin
    add_a = p_hi;
    add_b = mcand;
    case (state)
      S_PREP_A: begin add_a = ~mcand; add_b = ONE; end
      S_PREP_B: begin add_a = ~p_lo;  add_b = ONE; end
      S_FIX_LO: begin add_a = ~p_lo;  add_b = ONE; end
      S_FIX_HI: begin add_a = ~p_hi;  add_b = {{(WIDTH-1){1'b0}}, carry_r}; end
      default:  begin add_a = p_hi;   add_b = mcand; end
    endcase
  end

  add32 u_add (
    .a        (add_a),
    .b        (add_b),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (add_ovf_unused)
  );

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      count   <= '0;
      sgn     <= 1'b0;
      neg     <= 1'b0;
      carry_r <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= op_a;
            p_lo  <= op_b;
            sgn   <= is_signed;
            neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            state <= S_PREP_A;
          end
        end
        S_PREP_A: begin
          if (sgn & mcand[WIDTH-1]) mcand <= add_sum;
          state <= S_PREP_B;
        end
        S_PREP_B: begin
          // 0x80000000 negates to itself, which is the correct unsigned magnitude.
          if (sgn & p_lo[WIDTH-1]) p_lo <= add_sum;
          p_hi  <= '0;
          count <= '0;
          state <= S_MUL;
        end
        S_MUL: begin
          if (p_lo[0]) begin
            p_hi <= {add_cout, add_sum[WIDTH-1:1]};
            p_lo <= {add_sum[0], p_lo[WIDTH-1:1]};
          end else begin
            p_hi <= {1'b0, p_hi[WIDTH-1:1]};
            p_lo <= {p_hi[0], p_lo[WIDTH-1:1]};
          end
          count <= count + 5'd1;
          if (count == 5'd31) state <= S_FIX_LO;
        end
        S_FIX_LO: begin
          if (neg) begin
            p_lo    <= add_sum;
            carry_r <= add_cout;
          end else begin
            carry_r <= 1'b0;
          end
          state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          if (neg) p_hi <= add_sum;
          hi    <= neg ? add_sum : p_hi;
          lo    <= p_lo;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_ctrl
// Brief    : Directed self-checking bench for mult_seq_ctrl.
// Revision : 1.0
// ============================================================================

module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mult_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Start a multiply, then check latency, busy length, result and return to idle.
  task automatic run_mult(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
    int done_at;
    int busy_cnt;
    @(negedge clk);
    is_signed = sgn; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_cnt = busy ? 1 : 0;
    done_at  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
    end
    check({tag, " latency"}, 64'(done_at), 64'd36);
    check({tag, " busy_len"}, 64'(busy_cnt), 64'd37);
    check({tag, " product"}, {hi, lo}, {exp_hi, exp_lo});
    @(posedge clk);
    #1;
    check({tag, " idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int done_cnt;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    #1;
    check("reset_outputs", {30'd0, busy, done, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_mult("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_mult("mult_m3x5", 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_mult("mult_m1x0", 1'b1, 32'hFFFFFFFF, 32'd0,        32'h00000000, 32'h00000000);
    run_mult("mult_minsq", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_mult("mult_minx1", 1'b1, 32'h80000000, 32'd1,       32'hFFFFFFFF, 32'h80000000);

    // 7x6 with stray starts mid-run and in DONE, and operands changing after acceptance.
    @(negedge clk);
    is_signed = 1'b0; op_a = 32'd7; op_b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == 10) || (k == 37);
      if (k == 5)  op_a = 32'd99;
      if (k == 10) begin op_a = 32'd2; op_b = 32'd2; end
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        check("interf_product", {hi, lo}, {32'd0, 32'd42});
      end
      if (k == 20 || k == 35) check("interf_hold", {hi, lo}, {32'hFFFFFFFF, 32'h80000000});
    end
    start = 1'b0;
    check("interf_done_cnt", 64'(done_cnt), 64'd1);
    check("interf_idle", {63'd0, busy}, 64'd0);

    // Asynchronous reset at cycle 12 of a 100x100 run.
    @(negedge clk);
    is_signed = 1'b0; op_a = 32'd100; op_b = 32'd100; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", {62'd0, busy, done}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (k == 3) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    check("async_rst_no_done", 64'(done_cnt), 64'd0);
    run_mult("multu_100sq", 1'b0, 32'd100, 32'd100, 32'd0, 32'd10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Multi-cycle sequencer for MIPS MULT/MULTU. It produces a 64-bit product into HI/LO.
- All arithmetic goes through one internal instance of the existing 32-bit ripple/CSA adder wrapper, which has a carry-in of 0, a `sum` output and a `cout` output. No other adders or multipliers are allowed.
- The block sits beside the ALU in the execute stage. The pipeline stalls while `busy` is high.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported because it must match the adder.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply. Sampled only in IDLE.
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU. Latched with `start`.
- op_a  input  32  multiplicand (rs). Latched with `start`.
- op_b  input  32  multiplier (rt). Latched with `start`.
- busy  output  1  high from the cycle after `start` is accepted until the DONE cycle inclusive.
- done  output  1  one-cycle pulse; `hi`/`lo` hold the new result in this cycle.
- hi  output  32  upper product word.
- lo  output  32  lower product word.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; `busy`, `done`, `hi`, `lo` = 0.
  - Internal registers cleared.
  - An operation in flight is abandoned and no `done` is issued.
- States: IDLE → PREP_A → PREP_B → MUL (32 iterations) → FIX_LO → FIX_HI → DONE → IDLE. The path is fixed regardless of signedness, so latency is constant.
- IDLE:
  - On `start`=1, latch the operands.
  - Set neg = is_signed & (op_a[31] ^ op_b[31]).
  - Go to PREP_A.
- PREP_A:
  - If is_signed & a[31], then mcand ← adder(~a, 1).sum. Otherwise mcand ← a.
- PREP_B:
  - If is_signed & b[31], then P_lo ← adder(~b, 1).sum. Otherwise P_lo ← b.
  - P_hi ← 0; iteration count ← 0.
  - Note: 0x80000000 negates to itself; treating it as unsigned magnitude 2^31 is correct.
- MUL, one iteration per cycle:
  - If P_lo[0]: {c, s} = adder(P_hi, mcand), then {P_hi, P_lo} ← {c, s, P_lo[31:1]}.
  - Otherwise: {P_hi, P_lo} ← {1'b0, P_hi, P_lo[31:1]}.
  - Exit to FIX_LO after iteration 31. The count is 5 bits and wraps to 0.
- FIX_LO:
  - If neg: P_lo ← adder(~P_lo, 1).sum and carry_r ← cout. The carry is 1 only when P_lo == 0.
  - Otherwise carry_r ← 0.
- FIX_HI:
  - If neg: P_hi ← adder(~P_hi, {31'b0, carry_r}).sum.
  - Result registers `hi` ← P_hi and `lo` ← P_lo are loaded on the edge leaving FIX_HI, using the final P_hi value.
- DONE:
  - `done`=1 and `busy`=1 for one cycle.
  - Next state is IDLE. A `start` in DONE is ignored; it must be re-asserted in IDLE.
- Latency: `start` sampled at edge E0. `done` is high between edges E36 and E37, i.e. 36 cycles. `busy` is high from E0 to E37.
- `start` while not in IDLE is ignored, and changes on `op_a`/`op_b`/`is_signed` after E0 have no effect.
- `hi`/`lo` hold the previous result until the next DONE, so MFHI/MFLO remain readable while busy.
- Adder `overflow` output is unused.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` high exactly 36 cycles after the `start` edge, for one cycle; `busy` high for 37 cycles.
- MULT −3 (0xFFFFFFFD) × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Same latency as the unsigned case.
- MULT 0x80000000 × 0x80000000 → `hi`=0x40000000, `lo`=0x00000000. MULT 0x80000000 × 1 → `hi`=0xFFFFFFFF, `lo`=0x80000000.
- MULT −1 × 0 (neg=1, zero product) → `hi`=0, `lo`=0, exercising the FIX_LO carry = 1 path.
- Stimulus: start 7×6, then pulse `start` with 2×2 at cycle 10 and again in the DONE cycle, and change `op_a` mid-run.
  - Response: only the result `lo`=42, `hi`=0; exactly one `done`; `hi`/`lo` keep the prior value until then.
- Stimulus: assert `rst_n`=0 asynchronously at cycle 12 of a MULTU 100×100 run.
  - Response: `busy`/`done`/`hi`/`lo` go to 0 immediately with no `done` pulse.
  - After release, MULTU 100×100 → `lo`=10000, `hi`=0.
